rs232_transceiver: RTL

//  Parametrised full-duplex RS232 transceiver. Successor to the separate RS232_Out/RS232_In pair.

---
 rtl/rs232_transceiver.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rs232_transceiver.sv
// Full-duplex RS232 transceiver: tick divider, TX/RX frame FSMs,
// 16x-oversampled receive with 2-flop synchroniser and an RX FIFO.
module rs232_transceiver #(
  parameter int DATA_WIDTH  = 9,
  parameter int CLK_DIV     = 4,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH:1]         transmit_data,
  input  logic                        transmit_data_en,
  output logic                        transmitting_data,
  output logic                        serial_data_out,
  input  logic                        serial_data_in,
  input  logic                        receive_data_en,
  output logic [DATA_WIDTH:1]         received_data,
  output logic                        data_received,
  input  logic                        read_en,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        receiving_data,
  output logic                        parity_error,
  output logic                        framing_error,
  output logic                        overrun,
  input  logic                        clear_errors
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int STOP_T = STOP_BITS * OVERSAMPLE;
  localparam int OS_W   = $clog2(STOP_T) + 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam bit HAS_PAR = (PARITY_MODE != 0);
  localparam logic ODD   = (PARITY_MODE == 2);

  // ---------------- tick divider ----------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {
    TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_state_t;

  tx_state_t           tx_state, tx_state_n;
  logic [OS_W-1:0]     tx_cnt, tx_cnt_n;
  logic [BIT_W-1:0]    tx_bit, tx_bit_n;
  logic [DATA_WIDTH:1] tx_sh, tx_sh_n;
  logic                tx_par, tx_par_n;
  logic [OS_W-1:0]     tx_lim;
  logic                tx_done;

  assign tx_lim  = (tx_state == TX_STOP) ? OS_W'(STOP_T - 1)
                                         : OS_W'(OVERSAMPLE - 1);
  assign tx_done = tick && (tx_cnt == tx_lim);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    if (tx_state != TX_IDLE && tx_state != TX_WAIT && tick)
      tx_cnt_n = tx_done ? '0 : tx_cnt + 1'b1;
    unique case (tx_state)
      TX_IDLE: begin
        if (transmit_data_en) begin
          tx_sh_n    = transmit_data;
          tx_par_n   = (^transmit_data) ^ ODD;
          tx_state_n = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tick) begin
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
        end
      end
      TX_START: begin
        if (tx_done) begin
          tx_state_n = TX_DATA;
          tx_bit_n   = '0;
        end
      end
      TX_DATA: begin
        if (tx_done) begin
          tx_sh_n = tx_sh >> 1;
          if (tx_bit == BIT_W'(DATA_WIDTH - 1))
            tx_state_n = HAS_PAR ? TX_PAR : TX_STOP;
          else
            tx_bit_n = tx_bit + 1'b1;
        end
      end
      TX_PAR:  if (tx_done) tx_state_n = TX_STOP;
      TX_STOP: if (tx_done) tx_state_n = TX_IDLE;
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
    end
  end

  // Line decoded from state so reset forces it high asynchronously.
  always_comb begin
    serial_data_out = 1'b1;
    unique case (tx_state)
      TX_START: serial_data_out = 1'b0;
      TX_DATA:  serial_data_out = tx_sh[1];
      TX_PAR:   serial_data_out = tx_par;
      default:  serial_data_out = 1'b1;
    endcase
  end

  assign transmitting_data = (tx_state != TX_IDLE);

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
  } rx_state_t;

  logic                rx_s1, rx_s2, rx_prev;
  rx_state_t           rx_state, rx_state_n;
  logic [OS_W-1:0]     rx_cnt, rx_cnt_n;
  logic [BIT_W-1:0]    rx_bit, rx_bit_n;
  logic [DATA_WIDTH:1] rx_sh, rx_sh_n;
  logic [OS_W-1:0]     rx_lim;
  logic                rx_hit;
  logic                push_req, push_n;
  logic                par_set, frm_set, ovr_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= serial_data_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // START waits half a bit, so later samples land mid-bit.
  assign rx_lim = (rx_state == RX_START) ? OS_W'(OVERSAMPLE / 2 - 1)
                                         : OS_W'(OVERSAMPLE - 1);
  assign rx_hit = tick && (rx_cnt == rx_lim);

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    push_n     = 1'b0;
    par_set    = 1'b0;
    frm_set    = 1'b0;
    if (rx_state != RX_IDLE && tick)
      rx_cnt_n = rx_hit ? '0 : rx_cnt + 1'b1;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        if (rx_hit) begin
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
          rx_bit_n   = '0;
        end
      end
      RX_DATA: begin
        if (rx_hit) begin
          rx_sh_n = {rx_s2, rx_sh[DATA_WIDTH:2]};
          if (rx_bit == BIT_W'(DATA_WIDTH - 1))
            rx_state_n = HAS_PAR ? RX_PAR : RX_STOP;
          else
            rx_bit_n = rx_bit + 1'b1;
        end
      end
      RX_PAR: begin
        if (rx_hit) begin
          par_set    = (rx_s2 != ((^rx_sh) ^ ODD));
          rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_hit) begin
          rx_state_n = RX_IDLE;
          push_n     = rx_s2;
          frm_set    = !rx_s2;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
    if (!receive_data_en) begin
      rx_state_n = RX_IDLE;
      push_n     = 1'b0;
      par_set    = 1'b0;
      frm_set    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      push_req <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      push_req <= push_n;
    end
  end

  assign receiving_data = (rx_state != RX_IDLE);

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH:1] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                pop, full, wr;

  assign pop     = read_en && (count != '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign wr      = push_req && (!full || pop);
  assign ovr_set = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= rx_sh;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign data_received = (count != '0);
  assign rx_count      = count;
  assign received_data = data_received ? mem[rd_ptr] : '0;

  // ---------------- sticky flags (set beats clear) ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      parity_error  <= par_set | (parity_error & ~clear_errors);
      framing_error <= frm_set | (framing_error & ~clear_errors);
      overrun       <= ovr_set | (overrun & ~clear_errors);
    end
  end

endmodule
